// File: rtl/mem_ctr.sv
// Main-memory model on the cache-to-memory bus: line-granular READ_LINE / WRITE_LINE
// with a fixed access latency, each line moved as a burst of DATA_W-bit beats.
`timescale 1ns/1ps
module mem_ctr #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int LINE_BYTES = 16,
    parameter int LATENCY    = 100
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] A2,
    input  logic [1:0]        C2_in,
    input  logic [DATA_W-1:0] D2_in,
    output logic [1:0]        C2_out,
    output logic [DATA_W-1:0] D2_out,
    output logic              bus_drive,
    output logic              busy
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAT_W  = $clog2(LATENCY + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    if (LATENCY < BEATS + 1) begin : g_bad_latency
        $error("mem_ctr: LATENCY must be at least BEATS+1");
    end

    typedef enum logic [2:0] {IDLE, WRITE_RX, WAIT, READ_TX, WRITE_ACK} state_t;

    // Power-up byte at byte address b is b[7:0].
    function automatic logic [LINE_W-1:0] pattern(input logic [ADDR_W-1:0] addr);
        logic [LINE_W-1:0] pat;
        logic [31:0]       ba;
        pat = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            ba = 32'(addr) * 32'(LINE_BYTES) + 32'(i);
            pat[i*8 +: 8] = ba[7:0];
        end
        return pat;
    endfunction

    // Storage holds each line XORed with its power-up pattern, so an all-zero
    // RAM image reads back as the power-up contents without any init sweep.
    logic [LINE_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [LAT_W-1:0]  lat_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;
    logic              is_read_q;
    logic [1:0]        c2_q;
    logic [DATA_W-1:0] d2_q;
    logic              drive_q;
    logic              busy_q;

    logic              commit_d;
    logic [LINE_W-1:0] commit_line_d;

    always_comb begin
        commit_d      = !RESET && (state_q == WRITE_RX) && (beat_q == LAST_BEAT);
        commit_line_d = line_q;
        commit_line_d[int'(LAST_BEAT)*DATA_W +: DATA_W] = D2_in;
    end

    always_ff @(posedge CLK) begin
        if (commit_d)
            mem_q[addr_q] <= commit_line_d ^ pattern(addr_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            lat_q     <= '0;
            is_read_q <= 1'b0;
            c2_q      <= 2'd0;
            d2_q      <= '0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (C2_in == CMD_READ || C2_in == CMD_WRITE) begin
                        addr_q <= A2;
                        busy_q <= 1'b1;
                        lat_q  <= LAT_W'(1);
                        if (C2_in == CMD_READ) begin
                            line_q    <= mem_q[A2] ^ pattern(A2);
                            is_read_q <= 1'b1;
                            state_q   <= WAIT;
                        end else begin
                            line_q[DATA_W-1:0] <= D2_in;
                            is_read_q <= 1'b0;
                            beat_q    <= BEAT_W'(1);
                            state_q   <= WRITE_RX;
                        end
                    end
                end
                WRITE_RX: begin
                    line_q[int'(beat_q)*DATA_W +: DATA_W] <= D2_in;
                    lat_q <= lat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_q  <= '0;
                        state_q <= WAIT;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                WAIT: begin
                    // Registered outputs: switch one cycle early so the first
                    // response cycle lands exactly LATENCY cycles after acceptance.
                    if (lat_q == LAT_LAST) begin
                        c2_q    <= 2'd1;
                        drive_q <= 1'b1;
                        beat_q  <= '0;
                        if (is_read_q) begin
                            d2_q    <= line_q[DATA_W-1:0];
                            state_q <= READ_TX;
                        end else begin
                            d2_q    <= '0;
                            state_q <= WRITE_ACK;
                        end
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                READ_TX: begin
                    if (beat_q == LAST_BEAT) begin
                        c2_q    <= 2'd0;
                        d2_q    <= '0;
                        drive_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                        d2_q   <= line_q[(int'(beat_q) + 1)*DATA_W +: DATA_W];
                    end
                end
                WRITE_ACK: begin
                    c2_q    <= 2'd0;
                    d2_q    <= '0;
                    drive_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C2_out    = c2_q;
    assign D2_out    = d2_q;
    assign bus_drive = drive_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_ctr.sv
// Scoreboard bench for mem_ctr: directed commands push expected response beats,
// a negedge monitor pops and compares them with their exact arrival cycle.
`timescale 1ns/1ps
module tb_mem_ctr;
    localparam int ADDR_W = 15, DATA_W = 16, LINE_BYTES = 16, LATENCY = 100, BEATS = 8;

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic [ADDR_W-1:0] A2 = '0;
    logic [1:0]        C2_in = 2'd0;
    logic [DATA_W-1:0] D2_in = '0;
    logic [1:0]        C2_out;
    logic [DATA_W-1:0] D2_out;
    logic              bus_drive;
    logic              busy;

    always #5 clk = ~clk;

    mem_ctr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_BYTES(LINE_BYTES), .LATENCY(LATENCY)) dut (
        .CLK(clk), .RESET(RESET), .A2(A2), .C2_in(C2_in), .D2_in(D2_in),
        .C2_out(C2_out), .D2_out(D2_out), .bus_drive(bus_drive), .busy(busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [15:0] data; } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (C2_out != 2'd0) begin
                if (q.size() == 0) begin
                    check("unexpected_resp", 32'(C2_out), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("resp_cycle", cyc, mon_e.cyc);
                    check("resp_cmd", 32'(C2_out), 32'd1);
                    check("resp_data", 32'(D2_out), 32'(mon_e.data));
                    check("resp_drive", 32'(bus_drive), 32'd1);
                end
            end else begin
                check("idle_data", 32'(D2_out), 32'd0);
                check("idle_drive", 32'(bus_drive), 32'd0);
            end
        end
    end

    // Power-up beat k of line a: bytes {a,2k+1} and {a,2k} (low byte address nibble pairs).
    function automatic logic [15:0] pu_beat(input logic [ADDR_W-1:0] a, input int k);
        logic [3:0] lo, hi;
        lo = 4'(2*k);
        hi = 4'(2*k + 1);
        return {a[3:0], hi, a[3:0], lo};
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // All driver tasks start and end just after a falling edge.
    task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [15:0] eb [BEATS], output int t0);
        exp_t e;
        C2_in = 2'd2;
        A2 = a;
        t0 = cyc;
        for (int k = 0; k < BEATS; k++) begin
            e.cyc = t0 + LATENCY + k;
            e.data = eb[k];
            q.push_back(e);
        end
        @(negedge clk);
        C2_in = 2'd0;
    endtask

    task automatic issue_write(input logic [ADDR_W-1:0] a, input logic [15:0] b [BEATS],
                               input bit expect_ack, input int rst_k, output int t0);
        exp_t e;
        C2_in = 2'd3;
        A2 = a;
        D2_in = b[0];
        t0 = cyc;
        if (expect_ack) begin
            e.cyc = t0 + LATENCY;
            e.data = 16'h0000;
            q.push_back(e);
        end
        @(negedge clk);
        C2_in = 2'd0;
        for (int k = 1; k < BEATS; k++) begin
            D2_in = b[k];
            RESET = (k == rst_k);
            @(negedge clk);
        end
        RESET = 1'b0;
        D2_in = '0;
    endtask

    task automatic read_and_finish(input logic [ADDR_W-1:0] a, input logic [15:0] eb [BEATS]);
        int t;
        issue_read(a, eb, t);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_until(t + LATENCY + BEATS);
        check("busy_after_read", 32'(busy), 32'd0);
        check("queue_drained", q.size(), 32'd0);
    endtask

    logic [15:0] vec [BEATS];
    logic [15:0] wv  [BEATS];
    int t0, t1;

    initial begin
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Reset with a READ_LINE present: not accepted
        RESET = 1'b1; C2_in = 2'd2; A2 = 15'h0003;
        @(negedge clk);
        RESET = 1'b0; C2_in = 2'd0;
        check("rst_c2", 32'(C2_out), 32'd0);
        check("rst_d2", 32'(D2_out), 32'd0);
        check("rst_drive", 32'(bus_drive), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_no_accept", 32'(busy), 32'd0);

        // Ignored command code 1
        C2_in = 2'd1;
        @(negedge clk);
        C2_in = 2'd0;
        check("cmd1_ignored", 32'(busy), 32'd0);

        // Power-up read of line 3, then back-to-back read of line 0x12
        for (int k = 0; k < BEATS; k++) vec[k] = pu_beat(15'h0003, k);
        check("pu_vec0", 32'(vec[0]), 32'h3130);
        check("pu_vec7", 32'(vec[7]), 32'h3F3E);
        issue_read(15'h0003, vec, t0);
        check("busy_T0p1", 32'(busy), 32'd1);
        wait_until(t0 + LATENCY + BEATS - 1);
        check("busy_last_beat", 32'(busy), 32'd1);
        wait_until(t0 + LATENCY + BEATS);
        check("c2_after_read", 32'(C2_out), 32'd0);
        check("busy_after_read", 32'(busy), 32'd0);
        for (int k = 0; k < BEATS; k++) vec[k] = pu_beat(15'h0012, k);
        check("pu12_vec0", 32'(vec[0]), 32'h2120);
        read_and_finish(15'h0012, vec);

        // Write line 5, then read it back and check a neighbour
        for (int k = 0; k < BEATS; k++) wv[k] = 16'hA000 + 16'(k);
        issue_write(15'h0005, wv, 1'b1, -1, t0);
        wait_until(t0 + LATENCY);
        check("busy_at_ack", 32'(busy), 32'd1);
        wait_until(t0 + LATENCY + 1);
        check("busy_after_ack", 32'(busy), 32'd0);
        check("ack_seen", q.size(), 32'd0);
        read_and_finish(15'h0005, wv);
        for (int k = 0; k < BEATS; k++) vec[k] = pu_beat(15'h0004, k);
        read_and_finish(15'h0004, vec);

        // Write attempted while busy is ignored
        for (int k = 0; k < BEATS; k++) vec[k] = pu_beat(15'h0003, k);
        issue_read(15'h0003, vec, t1);
        wait_until(t1 + 10);
        C2_in = 2'd3; A2 = 15'h0003; D2_in = 16'hBEEF;
        repeat (BEATS) @(negedge clk);
        C2_in = 2'd0; D2_in = '0;
        wait_until(t1 + LATENCY + BEATS + 2);
        check("busy_ignore_done", 32'(busy), 32'd0);
        check("busy_ignore_q", q.size(), 32'd0);
        read_and_finish(15'h0003, vec);

        // Reset in the middle of a write burst: no response, storage untouched
        for (int k = 0; k < BEATS; k++) wv[k] = 16'hC000 + 16'(k);
        issue_write(15'h0007, wv, 1'b0, 4, t0);
        check("midrst_busy", 32'(busy), 32'd0);
        wait_until(t0 + LATENCY + 10);
        for (int k = 0; k < BEATS; k++) vec[k] = pu_beat(15'h0007, k);
        check("pu7_vec0", 32'(vec[0]), 32'h7170);
        read_and_finish(15'h0007, vec);

        // Reset after the commit: no ack, but the write persists
        for (int k = 0; k < BEATS; k++) wv[k] = 16'hD000 + 16'(k);
        issue_write(15'h0009, wv, 1'b0, -1, t0);
        wait_until(t0 + 20);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        check("postrst_busy", 32'(busy), 32'd0);
        wait_until(t0 + LATENCY + 10);
        read_and_finish(15'h0009, wv);

        check("final_queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
